complete_sub_seq: RTL and testbench

//  Multi-cycle floating-point subtractor, res = opA - opB, companion to the combinational adder.

---
 rtl/complete_sub_seq.sv | 154 +++++++++++++++
 tb/tb_complete_sub_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/complete_sub_seq.sv
// complete_sub_seq: multi-cycle floating-point subtractor, res = opA - opB
//
// Operand / result format: [31:24] signed exponent E, [23:0] signed mantissa M,
// value = M * 2^E. One operation in flight, valid/ready on both sides.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset, returns to IDLE and clears outputs
//   in_valid   opA/opB valid
//   in_ready   operands accepted (high only in IDLE)
//   opA        minuend
//   opB        subtrahend
//   out_valid  res/overflow valid, held until out_ready
//   out_ready  consumer accepts result
//   res        {exponent[7:0], mantissa[23:0]}
//   overflow   exponent saturated at +127
//
// Optional feature: define NORM_LEFT_EN to enable left normalisation in NORM.
// Without it the result keeps the aligned exponent, matching the adder.
module complete_sub_seq #(
    parameter int MAX_ALIGN = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] res,
    output logic        overflow
);

    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

    localparam logic signed [8:0] MAX_A = 9'(MAX_ALIGN);

    state_t             state_q, state_d;
    logic signed [8:0]  ea_q, ea_d, eb_q, eb_d, e_q, e_d;
    logic signed [23:0] ma_q, ma_d, mb_q, mb_d;
    logic signed [24:0] d_q, d_d;
    logic [31:0]        res_q, res_d;
    logic               ovf_q, ovf_d;
    logic signed [8:0]  de;
    logic signed [8:0]  de_neg;
    logic               fits;

    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        d_d     = d_q;
        e_d     = e_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        // 9-bit difference of sign-extended exponents cannot wrap
        de      = ea_q - eb_q;
        de_neg  = eb_q - ea_q;
        // the 25-bit difference fits 24 bits when its top two bits agree
        fits    = d_q[24] == d_q[23];
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ea_d    = {opA[31], opA[31:24]};
                    eb_d    = {opB[31], opB[31:24]};
                    ma_d    = opA[23:0];
                    mb_d    = opB[23:0];
                    ovf_d   = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (de == 9'sd0) begin
                    state_d = SUB;
                end else if (de > 9'sd0) begin
                    // beyond MAX_A every bit of B's mantissa would shift out
                    eb_d = (de > MAX_A) ? ea_q : eb_q + 9'sd1;
                    mb_d = (de > MAX_A) ? {24{mb_q[23]}} : mb_q >>> 1;
                end else begin
                    ea_d = (de_neg > MAX_A) ? eb_q : ea_q + 9'sd1;
                    ma_d = (de_neg > MAX_A) ? {24{ma_q[23]}} : ma_q >>> 1;
                end
            end
            SUB: begin
                d_d     = {ma_q[23], ma_q} - {mb_q[23], mb_q};
                e_d     = ea_q;
                state_d = NORM;
            end
            NORM: begin
                if (!fits) begin
                    if (e_q == 9'sd127) begin
                        res_d   = {8'h7F, d_q[24] ? 24'h800000 : 24'h7FFFFF};
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        d_d = d_q >>> 1;
                        e_d = e_q + 9'sd1;
                    end
                end else if (d_q == '0) begin
                    res_d   = '0;
                    state_d = DONE;
                end
`ifdef NORM_LEFT_EN
                // redundant sign bit and exponent headroom: shift left once more
                else if (d_q[23] == d_q[22] && e_q != -9'sd128) begin
                    d_d = d_q <<< 1;
                    e_d = e_q - 9'sd1;
                end
`endif
                else begin
                    res_d   = {e_q[7:0], d_q[23:0]};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            d_q     <= '0;
            e_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            d_q     <= d_d;
            e_q     <= e_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign res       = res_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_complete_sub_seq.sv
// tb_complete_sub_seq: directed-vector bench for complete_sub_seq
module tb_complete_sub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] res;
    logic        overflow;

    int vec = 0;
    int err = 0;

    complete_sub_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opA(opA), .opB(opB),
        .out_valid(out_valid), .out_ready(out_ready),
        .res(res), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Called at 1 time unit after a rising edge with the DUT in IDLE.
    // lat counts rising edges from the accept edge until out_valid is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic o, output int lat);
        in_valid = 1'b1;
        opA = a;
        opB = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res;
        o = overflow;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        vec++; if (res !== 32'h0) begin err++; $display("FAIL reset res got %h want 00000000", res); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL reset overflow got %b want 0", overflow); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_equal_exp();
        logic [31:0] a[3] = '{32'h04000004, 32'h12345678, 32'h80000001};
        logic [31:0] b[3] = '{32'h04000001, 32'h12345678, 32'h80000000};
`ifdef NORM_LEFT_EN
        logic [31:0] er[3] = '{32'hEF600000, 32'h00000000, 32'h80000001};
        int          el[3] = '{24, 3, 3};
`else
        logic [31:0] er[3] = '{32'h04000003, 32'h00000000, 32'h80000001};
        int          el[3] = '{3, 3, 3};
`endif
        logic [31:0] r;
        logic        o;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            do_op(a[i], b[i], r, o, lat);
            vec++; if (r !== er[i]) begin err++; $display("FAIL equal_exp[%0d] res got %h want %h", i, r, er[i]); end
            vec++; if (o !== 1'b0) begin err++; $display("FAIL equal_exp[%0d] overflow got %b want 0", i, o); end
            vec++; if (lat != el[i]) begin err++; $display("FAIL equal_exp[%0d] latency got %0d want %0d", i, lat, el[i]); end
            release_out();
        end
    endtask

    task automatic test_align();
        logic [31:0] a[6] = '{32'h04000004, 32'h20000010, 32'h20000010,
                              32'h00000006, 32'h18000010, 32'h19000010};
        logic [31:0] b[6] = '{32'h020000FF, 32'h00000005, 32'h00FFFFF0,
                              32'h01000001, 32'h00400000, 32'h00400000};
`ifdef NORM_LEFT_EN
        logic [31:0] er[6] = '{32'hF38A0000, 32'h0E400000, 32'h0E440000,
                               32'hEC400000, 32'h06400000, 32'h07400000};
        int          el[6] = '{22, 22, 22, 25, 45, 22};
`else
        logic [31:0] er[6] = '{32'h04FFFFC5, 32'h20000010, 32'h20000011,
                               32'h01000002, 32'h18000010, 32'h19000010};
        int          el[6] = '{5, 4, 4, 4, 27, 4};
`endif
        logic [31:0] r;
        logic        o;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            do_op(a[i], b[i], r, o, lat);
            vec++; if (r !== er[i]) begin err++; $display("FAIL align[%0d] res got %h want %h", i, r, er[i]); end
            vec++; if (o !== 1'b0) begin err++; $display("FAIL align[%0d] overflow got %b want 0", i, o); end
            vec++; if (lat != el[i]) begin err++; $display("FAIL align[%0d] latency got %0d want %0d", i, lat, el[i]); end
            release_out();
        end
    endtask

    task automatic test_right_norm();
        logic [31:0] a[5] = '{32'h017FFFFF, 32'h01800000, 32'h7E7FFFFF, 32'h7F800000, 32'h7F7FFFFF};
        logic [31:0] b[5] = '{32'h01800000, 32'h017FFFFF, 32'h7E800000, 32'h7F7FFFFF, 32'h7F800000};
        logic [31:0] er[5] = '{32'h027FFFFF, 32'h02800000, 32'h7F7FFFFF, 32'h7F800000, 32'h7F7FFFFF};
        logic        eo[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int          el[5] = '{4, 4, 4, 3, 3};
        logic [31:0] r;
        logic        o;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_op(a[i], b[i], r, o, lat);
            vec++; if (r !== er[i]) begin err++; $display("FAIL right_norm[%0d] res got %h want %h", i, r, er[i]); end
            vec++; if (o !== eo[i]) begin err++; $display("FAIL right_norm[%0d] overflow got %b want %b", i, o, eo[i]); end
            vec++; if (lat != el[i]) begin err++; $display("FAIL right_norm[%0d] latency got %0d want %0d", i, lat, el[i]); end
            release_out();
        end
    endtask

    // Entered with the last result an overflow, so res and overflow are non-zero.
    task automatic test_reset_mid();
        in_valid = 1'b1;
        opA = 32'h10000001;
        opB = 32'h00000001;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL reset_mid busy in_ready got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_mid in_ready got %b want 1", in_ready); end
        vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_mid out_valid got %b want 0", out_valid); end
        vec++; if (res !== 32'h0) begin err++; $display("FAIL reset_mid res got %h want 00000000", res); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL reset_mid overflow got %b want 0", overflow); end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_mid stale out_valid cycle %0d got %b want 0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
`ifdef NORM_LEFT_EN
        logic [31:0] er = 32'hEF600000;
        int          el = 24;
`else
        logic [31:0] er = 32'h04000003;
        int          el = 3;
`endif
        logic [31:0] r;
        logic        o;
        int          lat;
        do_op(32'h04000004, 32'h04000001, r, o, lat);
        vec++; if (r !== er) begin err++; $display("FAIL backpressure res got %h want %h", r, er); end
        vec++; if (lat != el) begin err++; $display("FAIL backpressure latency got %0d want %0d", lat, el); end
        for (int i = 0; i < 6; i++) begin
            in_valid = (i == 2);
            opA = 32'h7F7FFFFF;
            opB = 32'h7F800000;
            @(posedge clk); #1;
            vec++; if (res !== er) begin err++; $display("FAIL backpressure hold res cycle %0d got %h want %h", i, res, er); end
            vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL backpressure hold in_ready cycle %0d got %b want 0", i, in_ready); end
            vec++; if (out_valid !== 1'b1) begin err++; $display("FAIL backpressure hold out_valid cycle %0d got %b want 1", i, out_valid); end
        end
        in_valid = 1'b0;
        release_out();
        vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL backpressure release out_valid got %b want 0", out_valid); end
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL backpressure release in_ready got %b want 1", in_ready); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL backpressure overflow got %b want 0", overflow); end
        repeat (4) @(posedge clk);
        #1;
        vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL backpressure ignored pulse in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_left_norm();
`ifdef NORM_LEFT_EN
        logic [31:0] er = 32'hEE400000;
        int          el = 25;
`else
        logic [31:0] er = 32'h04000001;
        int          el = 3;
`endif
        logic [31:0] r;
        logic        o;
        int          lat;
        do_op(32'h04000004, 32'h04000003, r, o, lat);
        vec++; if (r !== er) begin err++; $display("FAIL left_norm res got %h want %h", r, er); end
        vec++; if (o !== 1'b0) begin err++; $display("FAIL left_norm overflow got %b want 0", o); end
        vec++; if (lat != el) begin err++; $display("FAIL left_norm latency got %0d want %0d", lat, el); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_equal_exp();
        test_align();
        test_right_norm();
        test_reset_mid();
        test_backpressure();
        test_left_norm();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
